// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, decode jump encodings and PC unit states.
package pipe_pkg;

   localparam logic [5:0] OP_BEQ  = 6'd32;
   localparam logic [5:0] OP_BNE  = 6'd33;
   localparam logic [5:0] OP_BLT  = 6'd34;
   localparam logic [5:0] OP_BLE  = 6'd35;
   localparam logic [5:0] OP_JR   = 6'd42;
   localparam logic [5:0] OP_HALT = 6'd63;

   // jon_d encodings from decode; bit 1 alone marks a pending branch/jr
   localparam logic [1:0] JON_NONE = 2'b00;
   localparam logic [1:0] JON_JUMP = 2'b01;
   localparam logic [1:0] JON_BR   = 2'b10;

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } pc_state_t;

endpackage

// File: rtl/pc_branch_cmp.sv
// Combinational resolver: picks the redirect target of the resolving instruction.
module pc_branch_cmp
   import pipe_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int ADDR_SHIFT = 2,
   parameter bit SIGNED_CMP = 1'b0
) (
   input  logic [5:0]      op,
   input  logic [XLEN-1:0] os,
   input  logic [XLEN-1:0] ot,
   input  logic [XLEN-1:0] imm_dpl,
   input  logic [XLEN-1:0] pc_in,
   output logic [XLEN-1:0] target
);

   logic [XLEN-1:0] seq;
   logic [XLEN-1:0] br;
   logic [XLEN-1:0] dpl_words;
   logic            lt;
   logic            eq;

   // Displacement is a byte offset; arithmetic shift keeps backward branches negative
   assign dpl_words = XLEN'($signed(imm_dpl) >>> ADDR_SHIFT);
   assign seq       = pc_in + XLEN'(1);
   assign br        = seq + dpl_words;
   assign eq        = (os == ot);

   generate
      if (SIGNED_CMP) begin : g_signed
         assign lt = ($signed(os) < $signed(ot));
      end else begin : g_unsigned
         assign lt = (os < ot);
      end
   endgenerate

   // Opcode decode of the taken/not-taken target; unknown opcodes fall through
   always_comb begin
      target = seq;
      case (op)
         OP_BEQ:  target = eq        ? br : seq;
         OP_BNE:  target = !eq       ? br : seq;
         OP_BLT:  target = lt        ? br : seq;
         OP_BLE:  target = (lt || eq) ? br : seq;
         OP_JR:   target = os;
         default: target = seq;
      endcase
   end

endmodule

// File: rtl/pc_unit_p.sv
// Fetch-stage program counter with direct jumps, delayed branch resolution,
// fetch stall, redirect flush pulse and a resumable HALT state.
module pc_unit_p
   import pipe_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter int              JW          = 26,
   parameter int              ADDR_SHIFT  = 2,
   parameter int              RESOLVE_LAT = 2,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter bit              SIGNED_CMP  = 1'b0
) (
   input  logic            clk,
   input  logic            rstd,
   input  logic            stall,
   input  logic            resume,
   input  logic [1:0]      jon_d,
   input  logic [JW-1:0]   addr_d,
   input  logic [5:0]      op,
   input  logic [XLEN-1:0] os,
   input  logic [XLEN-1:0] ot,
   input  logic [XLEN-1:0] imm_dpl,
   input  logic [XLEN-1:0] pc_in,
   output logic [XLEN-1:0] pc_out,
   output logic            flush,
   output logic            halted
);

   localparam logic [2:0] CNT_LOAD = 3'(RESOLVE_LAT);

   logic [XLEN-1:0] pc_reg, pc_next;
   logic [2:0]      cnt_reg, cnt_next;
   pc_state_t       state_reg, state_next;
   logic            flush_reg, flush_next;

   logic [XLEN-1:0] pc_plus1;
   logic [XLEN-1:0] jt;
   logic [JW-1:0]   addr_words;
   logic [XLEN-1:0] res_target;

   assign pc_plus1   = pc_reg + XLEN'(1);
   assign addr_words = addr_d >> ADDR_SHIFT;
   assign jt         = XLEN'(addr_words);

   pc_branch_cmp #(
      .XLEN       (XLEN),
      .ADDR_SHIFT (ADDR_SHIFT),
      .SIGNED_CMP (SIGNED_CMP)
   ) u_cmp (
      .op      (op),
      .os      (os),
      .ot      (ot),
      .imm_dpl (imm_dpl),
      .pc_in   (pc_in),
      .target  (res_target)
   );

   // State register; reset wins even in the middle of a countdown
   always_ff @(posedge clk) begin
      if (rstd) begin
         pc_reg    <= RESET_PC;
         cnt_reg   <= 3'd0;
         state_reg <= RUN;
         flush_reg <= 1'b0;
      end else begin
         pc_reg    <= pc_next;
         cnt_reg   <= cnt_next;
         state_reg <= state_next;
         flush_reg <= flush_next;
      end
   end

   // Next-state: prioritised pc action plus an independent resolve counter
   always_comb begin
      pc_next    = pc_reg;
      cnt_next   = cnt_reg;
      state_next = state_reg;
      flush_next = 1'b0;
      case (state_reg)
         RUN: begin
            if (!stall) begin
               if (jon_d == JON_JUMP) begin
                  // decode jump beats a resolution landing on the same edge
                  pc_next    = jt;
                  flush_next = 1'b1;
               end else if (cnt_reg == 3'd1) begin
                  // no flush when the resolved path equals sequential fetch
                  pc_next    = res_target;
                  flush_next = (res_target != pc_plus1);
               end else if (op == OP_HALT) begin
                  pc_next    = pc_in;
                  state_next = HALT;
               end else begin
                  pc_next = pc_plus1;
               end

               if (jon_d[1]) begin
                  cnt_next = CNT_LOAD;
               end else if (cnt_reg != 3'd0) begin
                  cnt_next = cnt_reg - 3'd1;
               end
            end
         end
         HALT: begin
            if (resume) begin
               pc_next    = pc_plus1;
               state_next = RUN;
            end
         end
         default: begin
            state_next = RUN;
         end
      endcase
   end

   assign pc_out = pc_reg;
   assign flush  = flush_reg;
   assign halted = (state_reg == HALT);

endmodule

// File: tb/tb_pc_unit_p.sv
// Directed bench for pc_unit_p: an unsigned-compare and a signed-compare
// instance share all inputs; expected values are hand-computed.
module tb_pc_unit_p;

   logic        clk = 1'b0;
   logic        rstd;
   logic        stall;
   logic        resume;
   logic [1:0]  jon_d;
   logic [25:0] addr_d;
   logic [5:0]  op;
   logic [31:0] os;
   logic [31:0] ot;
   logic [31:0] imm_dpl;
   logic [31:0] pc_in;

   logic [31:0] pc_out,   pc_out_s;
   logic        flush,    flush_s;
   logic        halted,   halted_s;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pc_unit_p #(.SIGNED_CMP(1'b0)) dut (
      .clk(clk), .rstd(rstd), .stall(stall), .resume(resume), .jon_d(jon_d),
      .addr_d(addr_d), .op(op), .os(os), .ot(ot), .imm_dpl(imm_dpl),
      .pc_in(pc_in), .pc_out(pc_out), .flush(flush), .halted(halted)
   );

   pc_unit_p #(.SIGNED_CMP(1'b1)) dut_s (
      .clk(clk), .rstd(rstd), .stall(stall), .resume(resume), .jon_d(jon_d),
      .addr_d(addr_d), .op(op), .os(os), .ot(ot), .imm_dpl(imm_dpl),
      .pc_in(pc_in), .pc_out(pc_out_s), .flush(flush_s), .halted(halted_s)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s got=%h", tag, got);
      end
   endtask

   // Checks the unsigned instance outputs
   task automatic chk(input string tag, input logic [31:0] e_pc, input logic e_fl, input logic e_h);
      check({tag, ".pc"},     pc_out,        e_pc);
      check({tag, ".flush"},  32'(flush),    32'(e_fl));
      check({tag, ".halted"}, 32'(halted),   32'(e_h));
   endtask

   // Checks the signed instance outputs
   task automatic chk_s(input string tag, input logic [31:0] e_pc, input logic e_fl, input logic e_h);
      check({tag, ".pc_s"},     pc_out_s,      e_pc);
      check({tag, ".flush_s"},  32'(flush_s),  32'(e_fl));
      check({tag, ".halted_s"}, 32'(halted_s), 32'(e_h));
   endtask

   // One clock edge; inputs are driven and outputs sampled on the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      stall = 0; resume = 0; jon_d = 2'b00; addr_d = '0;
      op = 6'd0; os = '0; ot = '0; imm_dpl = '0; pc_in = '0;
   endtask

   // Issue a pending branch and advance until the counter reaches 1
   task automatic arm_branch(input logic [31:0] pc_now);
      jon_d = 2'b10; step(); jon_d = 2'b00;
      check("arm1.pc", pc_out, pc_now + 32'd1);
      step();
      check("arm2.pc", pc_out, pc_now + 32'd2);
   endtask

   initial begin
      idle();
      rstd = 1'b1;
      @(negedge clk);
      step();
      chk("reset", 32'h0, 1'b0, 1'b0);
      chk_s("reset", 32'h0, 1'b0, 1'b0);

      // sequential fetch after release
      rstd = 1'b0;
      step(); chk("seq1", 32'h1, 1'b0, 1'b0);
      step(); chk("seq2", 32'h2, 1'b0, 1'b0);
      step(); chk("seq3", 32'h3, 1'b0, 1'b0);

      // direct jump
      jon_d = 2'b01; addr_d = 26'h100;
      step(); chk("jump", 32'h40, 1'b1, 1'b0);
      idle();
      step(); chk("jump+1", 32'h41, 1'b0, 1'b0);

      // beq taken
      arm_branch(32'h41);
      op = 6'd32; os = 32'd5; ot = 32'd5; pc_in = 32'h10; imm_dpl = 32'h20;
      step(); chk("beq_t", 32'h19, 1'b1, 1'b0); chk_s("beq_t", 32'h19, 1'b1, 1'b0);
      idle();
      step(); chk("beq_t+1", 32'h1A, 1'b0, 1'b0);

      // beq not taken
      arm_branch(32'h1A);
      op = 6'd32; os = 32'd4; ot = 32'd5; pc_in = 32'h10; imm_dpl = 32'h20;
      step(); chk("beq_nt", 32'h11, 1'b1, 1'b0);
      idle();

      // blt with os = -1, ot = 1: signed taken, unsigned not taken
      arm_branch(32'h11);
      op = 6'd34; os = 32'hFFFF_FFFF; ot = 32'd1; pc_in = 32'h10; imm_dpl = 32'h20;
      step(); chk("blt_u", 32'h11, 1'b1, 1'b0); chk_s("blt_s", 32'h19, 1'b1, 1'b0);
      idle();

      // resync both instances with a jump
      jon_d = 2'b01; addr_d = 26'h200;
      step(); chk("resync", 32'h80, 1'b1, 1'b0); chk_s("resync", 32'h80, 1'b1, 1'b0);
      idle();

      // negative displacement
      arm_branch(32'h80);
      op = 6'd32; pc_in = 32'h10; imm_dpl = 32'hFFFF_FFF0;
      step(); chk("neg_dpl", 32'h0D, 1'b1, 1'b0);
      idle();
      step(); chk("neg+1", 32'h0E, 1'b0, 1'b0);

      // resolution equal to sequential fetch: no flush
      arm_branch(32'h0E);
      op = 6'd33; pc_in = 32'h10;
      step(); chk("bne_seq", 32'h11, 1'b0, 1'b0);
      idle();

      // jump wins over a simultaneous resolution
      arm_branch(32'h11);
      jon_d = 2'b01; addr_d = 26'h300; op = 6'd32; pc_in = 32'h10; imm_dpl = 32'h20;
      step(); chk("jmp_vs_res", 32'hC0, 1'b1, 1'b0);
      idle();
      step(); chk("jmp_vs_res+1", 32'hC1, 1'b0, 1'b0);

      // halt, held despite stall/jon_d/op activity
      op = 6'd63; pc_in = 32'h30;
      step(); chk("halt", 32'h30, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         stall = i[0]; jon_d = (i % 3 == 0) ? 2'b01 : 2'b10;
         addr_d = 26'h3F0; op = 6'd32; pc_in = 32'h50;
         step(); chk("halt_hold", 32'h30, 1'b0, 1'b1);
      end
      idle();
      resume = 1'b1;
      step(); chk("resume", 32'h31, 1'b0, 1'b0);
      step(); chk("resume_run", 32'h32, 1'b0, 1'b0);
      resume = 1'b0;
      step(); chk("after_resume", 32'h33, 1'b0, 1'b0);

      // stall during countdown delays resolution by the stall length
      arm_branch(32'h33);
      stall = 1'b1; op = 6'd32; pc_in = 32'h10; imm_dpl = 32'h20;
      for (int i = 0; i < 3; i++) begin
         step(); chk("stall_hold", 32'h35, 1'b0, 1'b0);
      end
      stall = 1'b0;
      step(); chk("stall_res", 32'h19, 1'b1, 1'b0);
      idle();

      // reset mid-countdown: no later redirect
      jon_d = 2'b10;
      step(); chk("mid_arm", 32'h1A, 1'b0, 1'b0);
      jon_d = 2'b00; rstd = 1'b1; op = 6'd32; pc_in = 32'h10; imm_dpl = 32'h20;
      step(); chk("mid_rst", 32'h0, 1'b0, 1'b0);
      rstd = 1'b0;
      step(); chk("post_rst1", 32'h1, 1'b0, 1'b0);
      step(); chk("post_rst2", 32'h2, 1'b0, 1'b0);
      step(); chk("post_rst3", 32'h3, 1'b0, 1'b0);
      idle();

      // jr to all-ones, then silent wrap to zero
      arm_branch(32'h3);
      op = 6'd42; os = 32'hFFFF_FFFF;
      step(); chk("jr_max", 32'hFFFF_FFFF, 1'b1, 1'b0);
      idle();
      step(); chk("wrap", 32'h0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
